zapper_array: RTL



---
 rtl/zapper_array.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/zapper_array.sv
// Multi-channel light-gun front end: per-gun input synchronisers and a timed
// shot sequencer (BLANK -> LOOK -> HOLD -> REARM) feeding the player-input register.
`timescale 1ns/1ps

module zapper_array #(
  parameter int                NUM_GUNS           = 2,
  parameter int                SYNC_STAGES        = 2,
  parameter int                CNT_W              = 20,
  parameter logic [CNT_W-1:0]  BLANK_CYCLES       = 20'd16000,
  parameter logic [CNT_W-1:0]  LOOK_CYCLES        = 20'd33000,
  parameter logic [CNT_W-1:0]  HOLD_CYCLES        = 20'd50000,
  parameter bit                TRIG_ACTIVE_LOW    = 1'b1,
  parameter bit                SENSOR_ACTIVE_HIGH = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_GUNS-1:0] trigger,
  input  logic [NUM_GUNS-1:0] sensor,
  output logic [NUM_GUNS-1:0] shot,
  output logic [NUM_GUNS-1:0] hit,
  output logic [NUM_GUNS-1:0] result_stb,
  output logic                flash_req,
  output logic [15:0]         plyr_input
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_LOOK,
    ST_HOLD,
    ST_REARM
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] BLANK_LAST = BLANK_CYCLES - CNT_ONE;
  localparam logic [CNT_W-1:0] LOOK_LAST  = LOOK_CYCLES - CNT_ONE;
  localparam logic [CNT_W-1:0] HOLD_LAST  = HOLD_CYCLES - CNT_ONE;

  logic [NUM_GUNS-1:0] win_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GUNS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] trig_sync_reg;
      logic [SYNC_STAGES-1:0] sens_sync_reg;
      state_t                 state_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   shot_reg;
      logic                   hit_reg;
      logic                   stb_reg;
      logic                   win_reg;
      logic                   pulled;
      logic                   lit;

      // Polarity is folded in ahead of the first flop so that a cleared
      // synchroniser always reads as "released / dark" after reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          trig_sync_reg <= '0;
          sens_sync_reg <= '0;
        end else begin
          trig_sync_reg <= {trig_sync_reg[SYNC_STAGES-2:0], trigger[gi] ^ TRIG_ACTIVE_LOW};
          sens_sync_reg <= {sens_sync_reg[SYNC_STAGES-2:0], sensor[gi] ^ ~SENSOR_ACTIVE_HIGH};
        end
      end

      assign pulled = trig_sync_reg[SYNC_STAGES-1];
      assign lit    = sens_sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          shot_reg  <= 1'b0;
          hit_reg   <= 1'b0;
          stb_reg   <= 1'b0;
          win_reg   <= 1'b0;
        end else begin
          stb_reg <= 1'b0;
          case (state_reg)
            ST_IDLE: begin
              if (pulled) begin
                state_reg <= ST_BLANK;
                cnt_reg   <= '0;
                shot_reg  <= 1'b1;
                win_reg   <= 1'b1;
              end
            end
            ST_BLANK: begin
              if (cnt_reg == BLANK_LAST) begin
                state_reg <= ST_LOOK;
                cnt_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
            ST_LOOK: begin
              // Light takes priority, so a sample on the last look cycle still scores.
              if (lit || (cnt_reg == LOOK_LAST)) begin
                state_reg <= ST_HOLD;
                cnt_reg   <= '0;
                hit_reg   <= lit;
                win_reg   <= 1'b0;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
            ST_HOLD: begin
              if (cnt_reg == HOLD_LAST) begin
                state_reg <= pulled ? ST_REARM : ST_IDLE;
                cnt_reg   <= '0;
                shot_reg  <= 1'b0;
                hit_reg   <= 1'b0;
                stb_reg   <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
            ST_REARM: begin
              if (!pulled) begin
                state_reg <= ST_IDLE;
              end
            end
            default: begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
              shot_reg  <= 1'b0;
              hit_reg   <= 1'b0;
              win_reg   <= 1'b0;
            end
          endcase
        end
      end

      assign shot[gi]       = shot_reg;
      assign hit[gi]        = hit_reg;
      assign result_stb[gi] = stb_reg;
      assign win_bits[gi]   = win_reg;
    end
  endgenerate

  assign flash_req = |win_bits;

  always_comb begin
    plyr_input = '0;
    for (int i = 0; i < NUM_GUNS; i++) begin
      plyr_input[2*i]   = shot[i];
      plyr_input[2*i+1] = hit[i];
    end
  end

endmodule
